// File: rtl/ddr_ex_pattern_checker_pkg.sv
// Shared types and constants for the DDR read-pattern checker.
// Holds the FSM state type, the LFSR tap constant and the beat-count width.
package ddr_ex_pattern_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_TAP = 8'h1D;
    localparam int         BEAT_W   = 16;

endpackage

// File: rtl/ddr_ex_lfsr8_step.sv
// One combinational step of the 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1).
// Shared by checker lanes and any pattern generator.
module ddr_ex_lfsr8_step
    import ddr_ex_pattern_checker_pkg::*;
(
    input  logic [7:0] q,
    output logic [7:0] next
);

    assign next = {q[6:0], 1'b0} ^ (LFSR_TAP & {8{q[7]}});

endmodule

// File: rtl/ddr_ex_pattern_checker.sv
// Per-lane LFSR read-data checker with pass/fail status and error counting.
// Define DDR_EX_CHK_FIRST_ERR_EN to capture the first mismatching beat and lane mask.
module ddr_ex_pattern_checker
    import ddr_ex_pattern_checker_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int SEED_BASE  = 32,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    start,
    input  logic [BEAT_W-1:0]       expect_count,
    input  logic                    rd_valid,
    input  logic [8*DATA_BYTES-1:0] rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic [ERR_CNT_W-1:0]    err_count,
    output logic [BEAT_W-1:0]       beat_count,
    output logic [BEAT_W-1:0]       first_err_beat,
    output logic [DATA_BYTES-1:0]   first_err_mask
);

    state_t                state_q;
    state_t                state_d;
    logic [BEAT_W-1:0]     exp_q;
    logic [DATA_BYTES-1:0] lane_mism;
    logic                  start_ok;
    logic                  accept;
    logic                  beat_bad;
    logic                  last_beat;

    assign start_ok  = enable & start;
    assign accept    = enable & ~start & rd_valid & (state_q == ST_RUN);
    assign beat_bad  = |lane_mism;
    assign last_beat = (beat_count == exp_q - 1'b1);

    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        localparam logic [7:0] SEED = 8'((SEED_BASE + i) % 256);
        logic [7:0] lane_q;
        logic [7:0] lane_nx;

        ddr_ex_lfsr8_step u_step (
            .q    (lane_q),
            .next (lane_nx)
        );

        assign lane_mism[i] = (rd_data[8*i +: 8] != lane_q);

        // Expected-value register: reseeded on start/disable, stepped per beat
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                lane_q <= SEED;
            end else if (!enable || start) begin
                lane_q <= SEED;
            end else if (accept) begin
                lane_q <= lane_nx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a start in any state restarts the test
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (start_ok) begin
            state_d = (expect_count != '0) ? ST_RUN : ST_DONE;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN:  state_d = (accept && last_beat) ? ST_DONE : ST_RUN;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs decoded from registered state and counters
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
        pass = (state_q == ST_DONE) && (err_count == '0);
    end

    // Beat/error counters, sticky fail flag and latched beat target
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q      <= '0;
            beat_count <= '0;
            err_count  <= '0;
            fail       <= 1'b0;
        end else if (!enable) begin
            exp_q      <= '0;
            beat_count <= '0;
            err_count  <= '0;
            fail       <= 1'b0;
        end else if (start) begin
            exp_q      <= expect_count;
            beat_count <= '0;
            err_count  <= '0;
            fail       <= 1'b0;
        end else if (accept) begin
            beat_count <= beat_count + 1'b1;
            if (beat_bad) begin
                fail <= 1'b1;
                if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

`ifdef DDR_EX_CHK_FIRST_ERR_EN
    // First-mismatch capture; fail still low means this is the first one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_err_beat <= '0;
            first_err_mask <= '0;
        end else if (!enable || start) begin
            first_err_beat <= '0;
            first_err_mask <= '0;
        end else if (accept && beat_bad && !fail) begin
            first_err_beat <= beat_count;
            first_err_mask <= lane_mism;
        end
    end
`else
    assign first_err_beat = '0;
    assign first_err_mask = '0;
`endif

endmodule

// File: tb/tb_ddr_ex_pattern_checker.sv
// Scoreboard bench for ddr_ex_pattern_checker (2 lanes, 2-bit error counter).
// Expected lane values come from GF(2^8) arithmetic: seed * x^k mod 0x11D.
module tb_ddr_ex_pattern_checker;

    localparam int DB   = 2;
    localparam int EW   = 2;
    localparam int SB   = 32;
    localparam int EMAX = (1 << EW) - 1;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic [1:0]  err;
        logic [15:0] beats;
        logic [15:0] feb;
        logic [1:0]  fem;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          start;
    logic [15:0]   expect_count;
    logic          rd_valid;
    logic [15:0]   rd_data;
    logic          busy;
    logic          done;
    logic          pass;
    logic          fail;
    logic [EW-1:0] err_count;
    logic [15:0]   beat_count;
    logic [15:0]   first_err_beat;
    logic [DB-1:0] first_err_mask;

    int          errors = 0;
    int          checks = 0;
    bit          armed  = 1'b0;
    exp_t        sb_q[$];
    logic [15:0] stim_q[$];

    ddr_ex_pattern_checker #(
        .DATA_BYTES (DB),
        .SEED_BASE  (SB),
        .ERR_CNT_W  (EW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .start          (start),
        .expect_count   (expect_count),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail           (fail),
        .err_count      (err_count),
        .beat_count     (beat_count),
        .first_err_beat (first_err_beat),
        .first_err_mask (first_err_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane value after k steps: polynomial seed*x^k reduced mod x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] ref_val(input int lane, input int k);
        logic [63:0] v;
        v = 64'((SB + lane) % 256) << k;
        for (int b = 63; b >= 8; b--) begin
            if (v[b]) v = v ^ (64'h11D << (b - 8));
        end
        return v[7:0];
    endfunction

    function automatic logic [15:0] good_beat(input int k);
        return {ref_val(1, k), ref_val(0, k)};
    endfunction

    // Monitor: when a test reaches DONE, pop its expected result and compare
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (armed && done) begin
            armed = 1'b0;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_busy", 32'(busy), 0);
                chk("sb_pass", 32'(pass), 32'(e.pass));
                chk("sb_fail", 32'(fail), 32'(e.fail));
                chk("sb_err_count", 32'(err_count), 32'(e.err));
                chk("sb_beat_count", 32'(beat_count), 32'(e.beats));
                chk("sb_first_err_beat", 32'(first_err_beat), 32'(e.feb));
                chk("sb_first_err_mask", 32'(first_err_mask), 32'(e.fem));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_err_count"}, 32'(err_count), 0);
        chk({tag, "_beat_count"}, 32'(beat_count), 0);
        chk({tag, "_first_err_beat"}, 32'(first_err_beat), 0);
        chk({tag, "_first_err_mask"}, 32'(first_err_mask), 0);
    endtask

    // Run one test of n beats taken from stim_q; sv puts a beat in the start cycle
    task automatic run_seq(input int n, input bit sv);
        exp_t        e;
        int          errs;
        int          to;
        logic [1:0]  m;
        logic [15:0] d;
        errs = 0;
        e = '0;
        for (int k = 0; k < n; k++) begin
            d = stim_q[k];
            m[0] = (d[7:0] != ref_val(0, k));
            m[1] = (d[15:8] != ref_val(1, k));
            if (m != 2'b00) begin
                if (!e.fail) begin
                    e.feb = 16'(k);
                    e.fem = m;
                end
                e.fail = 1'b1;
                if (errs < EMAX) errs++;
            end
        end
        e.err   = 2'(errs);
        e.beats = 16'(n);
        e.pass  = !e.fail;
`ifndef DDR_EX_CHK_FIRST_ERR_EN
        e.feb = '0;
        e.fem = '0;
`endif
        sb_q.push_back(e);

        @(negedge clk);
        start        = 1'b1;
        expect_count = 16'(n);
        rd_valid     = sv;
        rd_data      = 16'hBEEF;
        armed        = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        rd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                rd_valid = 1'b0;
                rd_data  = 16'($urandom);
                @(negedge clk);
            end
            rd_valid = 1'b1;
            rd_data  = stim_q[k];
            @(negedge clk);
        end
        rd_valid = 1'b0;
        if (n > 0) chk("done_latency", 32'(done), 1);
        to = 0;
        while (armed && to < 20) begin
            @(negedge clk);
            to++;
        end
        if (armed) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=%0b expected done=1", done);
            armed = 1'b0;
            void'(sb_q.pop_front());
        end
    endtask

    task automatic fill_good(input int n);
        stim_q.delete();
        for (int k = 0; k < n; k++) stim_q.push_back(good_beat(k));
    endtask

    initial begin
        int n;
        logic [15:0] d;
        reset_n      = 1'b0;
        enable       = 1'b1;
        start        = 1'b0;
        expect_count = '0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Test 1: clean 4-beat run
        stim_q = '{16'h2120, 16'h4240, 16'h8480, 16'h151D};
        run_seq(4, 1'b0);

        // Test 2: lane 1 corrupt on beat 2
        stim_q = '{16'h2120, 16'h4240, 16'h8580, 16'h151D};
        run_seq(4, 1'b0);

        // Test 3: zero-length test, then a beat in DONE is ignored
        stim_q.delete();
        run_seq(0, 1'b0);
        rd_valid = 1'b1;
        rd_data  = 16'h1234;
        @(negedge clk);
        rd_valid = 1'b0;
        @(negedge clk);
        chk("done_beat_ignored", 32'(beat_count), 0);
        chk("done_hold", 32'(done), 1);

        // Test 4: five bad beats saturate the 2-bit counter
        stim_q.delete();
        for (int k = 0; k < 5; k++) stim_q.push_back(good_beat(k) ^ 16'h0001);
        run_seq(5, 1'b0);

        // Test 5: reset mid-test, then restart from the seeds
        @(negedge clk);
        start        = 1'b1;
        expect_count = 16'd4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd_valid = 1'b1;
            rd_data  = good_beat(k);
            @(negedge clk);
        end
        rd_valid = 1'b0;
        chk("pre_reset_beats", 32'(beat_count), 2);
        reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        fill_good(3);
        run_seq(3, 1'b0);

        // Test 6: beat in the start cycle is ignored
        fill_good(3);
        run_seq(3, 1'b1);

        // Disable mid-test clears everything and ignores start
        @(negedge clk);
        start        = 1'b1;
        expect_count = 16'd6;
        @(negedge clk);
        start    = 1'b0;
        rd_valid = 1'b1;
        rd_data  = 16'h0000;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("pre_disable_fail", 32'(fail), 1);
        enable = 1'b0;
        @(negedge clk);
        chk_zero("disable");
        start        = 1'b1;
        expect_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("disable_start_done", 32'(done), 0);
        enable = 1'b1;
        fill_good(2);
        run_seq(2, 1'b0);

        // Randomized tests with sporadic corruption
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 12);
            stim_q.delete();
            for (int k = 0; k < n; k++) begin
                d = good_beat(k);
                if ($urandom_range(0, 3) == 0) d = d ^ 16'($urandom_range(1, 65535));
                stim_q.push_back(d);
            end
            run_seq(n, 1'($urandom_range(0, 1)));
        end

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
